// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared LEGv8 pipeline widths, NOP encoding and fetch entry type
package cpu_pipe_pkg;

  localparam int INSN_W = 32;
  localparam int ADDR_W = 64;

  localparam logic [INSN_W-1:0] NOP_INSN = 32'hD503201F;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched instructions; flush wins over push
module fetch_queue
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - LEGv8 instruction fetch: PC, imem req/gnt + rvalid, fetch queue, redirect
// Optional perf counters under IF_FETCH_PERF_EN.
module if_fetch_unit
  import cpu_pipe_pkg::ADDR_W, cpu_pipe_pkg::INSN_W, cpu_pipe_pkg::fetch_entry_t;
#(
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter logic [INSN_W-1:0] NOP_INSN = cpu_pipe_pkg::NOP_INSN
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              dec_stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  output logic [INSN_W-1:0] instruction_out,
  output logic [ADDR_W-1:0] pc0_out,
  output logic [ADDR_W-1:0] pc_plus4_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target_aligned;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     qcount;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              cap_ok;
  logic              fire;
  logic              rsp;
  logic              push;
  logic              pop;
  logic              spurious_rvalid;

  // Capacity counts in-flight requests too, so a returning response always has a slot.
  assign cap_ok          = ({1'b0, outstanding} + {1'b0, qcount}) < (CW+1)'(QDEPTH);
  assign imem_req        = reset && !br_taken && cap_ok;
  assign imem_addr       = fetch_pc;
  assign fire            = imem_req && imem_gnt;
  assign spurious_rvalid = reset && imem_rvalid && (outstanding == '0);
  assign rsp             = imem_rvalid && (outstanding != '0);
  assign push            = rsp && !br_taken && (drop_cnt == '0);
  assign push_data       = '{insn: imem_rdata, pc: resp_pc};
  assign target_aligned  = {br_target[ADDR_W-1:2], 2'b00};

  assign if_valid        = (qcount != '0) && !br_taken;
  assign pop             = if_valid && !dec_stall;
  assign instruction_out = if_valid ? head.insn : NOP_INSN;
  assign pc0_out         = if_valid ? head.pc : '0;
  assign pc_plus4_out    = if_valid ? head.pc + 64'd4 : '0;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (br_taken),
    .count     (qcount),
    .head      (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (br_taken) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= target_aligned;
      resp_pc     <= target_aligned;
      drop_cnt    <= outstanding - CW'(rsp);
      outstanding <= outstanding - CW'(rsp);
    end else begin
      if (fire) fetch_pc <= fetch_pc + 64'd4;
      case ({fire, rsp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (rsp) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                resp_pc  <= resp_pc + 64'd4;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!spurious_rvalid)
        else $warning("if_fetch_unit: rvalid with no request outstanding, ignored");
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubbles   <= '0;
      perf_redirects <= '0;
    end else begin
      if (!if_valid && !dec_stall && !br_taken && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + 32'd1;
      if (br_taken && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with a 1-cycle in-order memory model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        if_valid;
  logic [31:0] instruction_out;
  logic [63:0] pc0_out;
  logic [63:0] pc_plus4_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_redirects;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_pc;
  logic [63:0] exp_addr;
  logic        auto_rsp;
  logic [63:0] pend [$];

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .dec_stall       (dec_stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .if_valid        (if_valid),
    .instruction_out (instruction_out),
    .pc0_out         (pc0_out),
    .pc_plus4_out    (pc_plus4_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_bubbles    (perf_bubbles),
    .perf_redirects  (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
  endtask

  // One clock: scoreboard pops and grants, then the memory returns the oldest grant next cycle.
  task automatic cycle();
    logic        f;
    logic        c;
    logic [63:0] a;
    f = imem_req && imem_gnt;
    a = imem_addr;
    c = imem_rvalid;
    if (if_valid && !dec_stall) begin
      chk("pop_pc", pc0_out, exp_pc);
      chk("pop_insn", {32'h0, instruction_out}, {32'h0, 32'h8B000000 + exp_pc[31:0]});
      chk("pop_pc4", pc_plus4_out, exp_pc + 64'd4);
      exp_pc = exp_pc + 64'd4;
    end
    if (f) begin
      chk("req_addr", a, exp_addr);
      exp_addr = exp_addr + 64'd4;
    end
    @(posedge clk);
    if (c && pend.size() > 0) void'(pend.pop_front());
    if (f) pend.push_back(a);
    @(negedge clk);
    if (auto_rsp && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h8B000000 + pend[0][31:0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    dec_stall   = 1'b0;
    br_taken    = 1'b0;
    br_target   = 64'h0;
    auto_rsp    = 1'b1;
    exp_pc      = 64'h0;
    exp_addr    = 64'h0;

    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_insn", instruction_out, 32'hD503201F);
    chk("rst_pc0", pc0_out, 64'h0);
    chk("rst_pc4", pc_plus4_out, 64'h0);

    // Streaming after reset release
    reset    = 1'b1;
    imem_gnt = 1'b1;
    #1;
    chk("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 64'h0);
    chk("c1_valid", if_valid, 1'b0);
    cycle();
    chk("c2_valid", if_valid, 1'b0);
    cycle();
    chk("c3_valid", if_valid, 1'b1);
    chk("c3_pc0", pc0_out, 64'h0);
    chk("c3_pc4", pc_plus4_out, 64'h4);
    repeat (12) cycle();

    // Decode stall fills the queue, then requests stop and the head holds
    dec_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) begin
        chk("stall_req", imem_req, 1'b0);
        chk("stall_valid", if_valid, 1'b1);
        chk("stall_pc0", pc0_out, exp_pc);
        chk("stall_insn", instruction_out, 32'h8B000000 + exp_pc[31:0]);
      end
      cycle();
    end

    // Drain with memory silent so two requests stay in flight
    dec_stall = 1'b0;
    auto_rsp  = 1'b0;
    repeat (4) cycle();
    chk("two_out_req", imem_req, 1'b0);
    chk("two_out_valid", if_valid, 1'b0);

    // Redirect to 0x103 with two stale responses pending
    auto_rsp  = 1'b1;
    br_taken  = 1'b1;
    br_target = 64'h103;
    #1;
    chk("br_req", imem_req, 1'b0);
    chk("br_valid", if_valid, 1'b0);
    cycle();
    br_taken = 1'b0;
    exp_pc   = 64'h100;
    exp_addr = 64'h100;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      cycle();
    end
    chk("br_next_req", imem_req, 1'b1);
    chk("br_next_addr", imem_addr, 64'h100);
    for (int i = 0; i < 10; i++) begin
      if (if_valid) break;
      cycle();
    end
    chk("br_first_valid", if_valid, 1'b1);
    chk("br_first_pc0", pc0_out, 64'h100);
    chk("br_first_insn", instruction_out, 32'h8B000100);
    repeat (6) cycle();

    // Redirect coinciding with rvalid and dec_stall
    for (int i = 0; i < 10; i++) begin
      if (imem_rvalid) break;
      cycle();
    end
    chk("rv_seen", imem_rvalid, 1'b1);
    dec_stall = 1'b1;
    br_taken  = 1'b1;
    br_target = 64'h200;
    #1;
    chk("brrv_valid", if_valid, 1'b0);
    chk("brrv_insn", instruction_out, 32'hD503201F);
    cycle();
    br_taken = 1'b0;
    exp_pc   = 64'h200;
    exp_addr = 64'h200;
    #1;
    chk("brrv_next_valid", if_valid, 1'b0);
    chk("brrv_next_insn", instruction_out, 32'hD503201F);
    chk("brrv_next_pc0", pc0_out, 64'h0);
    cycle();
    dec_stall = 1'b0;
    repeat (8) cycle();

    // Grant withheld: queue drains to bubbles and fetch_pc holds
    imem_gnt = 1'b0;
    repeat (5) cycle();
    chk("nognt_valid", if_valid, 1'b0);
    chk("nognt_insn", instruction_out, 32'hD503201F);
    chk("nognt_req", imem_req, 1'b1);
    chk("nognt_addr", imem_addr, exp_addr);
    imem_gnt = 1'b1;
    repeat (10) cycle();

    // Reset mid-stream with one request in flight
    for (int i = 0; i < 10; i++) begin
      if (pend.size() == 1) break;
      cycle();
    end
    chk("mid_one_out", pend.size(), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_valid", if_valid, 1'b0);
    chk("mid_rst_insn", instruction_out, 32'hD503201F);
    chk("mid_rst_pc0", pc0_out, 64'h0);
    chk("mid_rst_pc4", pc_plus4_out, 64'h0);
    @(negedge clk);
    pend.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_gnt    = 1'b0;
    auto_rsp    = 1'b0;
    exp_pc      = 64'h0;
    exp_addr    = 64'h0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 64'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    #1;
    chk("spurious_flag", dut.spurious_rvalid, 1'b1);
    cycle();
    chk("spurious_valid", if_valid, 1'b0);
    chk("spurious_req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    auto_rsp = 1'b1;
    repeat (8) cycle();
    chk("post_rst_progress", exp_pc >= 64'h8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that feeds the IF/DEC pipeline buffer of the 5-stage LEGv8 pipeline.
- Owns the PC and issues requests to a variable-latency instruction memory (req/gnt, rvalid/rdata).
- Holds returned instructions in a small fetch queue and presents one instruction per cycle.
- Supports decode stall, branch redirect with discard of in-flight responses, and NOP bubble insertion.

Parameters:
- QDEPTH, 2: fetch-queue entries; also the maximum outstanding plus queued instructions.
- RESET_PC, 64'h0: PC value after reset.
- NOP_INSN, 32'hD503201F: instruction presented on a bubble.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch byte address, 4-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction.
- dec_stall  in  1  hazard unit holds decode; do not pop.
- br_taken  in  1  redirect fetch this cycle.
- br_target  in  64  redirect address; bits [1:0] are forced to 0.
- if_valid  out  1  queue head valid.
- instruction_out  out  32  head instruction, or NOP_INSN when invalid.
- pc0_out  out  64  address of the head instruction (0 when invalid).
- pc_plus4_out  out  64  pc0_out + 4 (0 when invalid).

Behaviour:
- Reset (asynchronous, reset==0):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - outstanding = 0, drop_cnt = 0, queue empty.
  - imem_req = 0, if_valid = 0, instruction_out = NOP_INSN, pc outputs = 0.
- Request issue:
  - imem_req = !br_taken && (outstanding + qcount < QDEPTH).
  - imem_addr = fetch_pc.
  - On req && gnt: fetch_pc += 4 (64-bit wrap), outstanding++.
- Response handling:
  - On rvalid with drop_cnt > 0: discard, drop_cnt--, outstanding--.
  - On rvalid with drop_cnt == 0: push {rdata, resp_pc}, resp_pc += 4, outstanding--.
  - Push never overflows, because the capacity check includes outstanding.
- Output (combinational from the queue head):
  - if_valid = qcount != 0 && !br_taken.
  - Pop when if_valid && !dec_stall.
  - Push and pop may occur in the same cycle; the head latency is then 1 cycle after rvalid (no same-cycle bypass).
- Redirect (br_taken):
  - Flush the queue.
  - fetch_pc <= target, resp_pc <= target.
  - drop_cnt <= outstanding − rvalid. Any response arriving in the redirect cycle is discarded.
  - No request is issued that cycle.
  - Redirect has priority over dec_stall and over push/pop.
- Simultaneous redirect and gnt: impossible, because imem_req is low.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding.
- rvalid while outstanding == 0 is a protocol violation: ignore it and fire an assertion.
- Stall with the queue full: requests stop and the head holds stable.
- Counter widths: outstanding, drop_cnt and qcount are $clog2(QDEPTH+1) bits.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_bubbles (32) and perf_redirects (32).
  - perf_bubbles counts cycles where !if_valid && !dec_stall && !br_taken.
  - perf_redirects counts br_taken cycles.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: neither port nor counter logic exists.

Decomposition:
- Shared package cpu_pipe_pkg:
  - NOP_INSN constant.
  - INSN_W = 32 and ADDR_W = 64.
  - Typedef fetch_entry_t {insn[31:0], pc[63:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, head. Flush has priority over push.

Test Plan:
- Reset release, imem_gnt=1, fixed 1-cycle rdata = 0x8B000000+addr → imem_addr sequence 0,4,8…; if_valid from cycle 3; pc0_out 0,4,8; pc_plus4_out 4,8,12.
- dec_stall=1 for 4 cycles with QDEPTH=2 → at most 2 requests outstanding/queued, imem_req=0, head instruction and pc0_out stable.
- br_taken with br_target=0x103 while 2 requests outstanding → next imem_addr=0x100; the 2 stale responses are discarded; first valid pc0_out=0x100.
- br_taken in the same cycle as rvalid and dec_stall → response discarded, queue empty next cycle, if_valid=0, instruction_out=0xD503201F.
- imem_gnt low for 5 cycles → if_valid drops to 0 and NOP bubbles appear; fetch_pc is held and resumes without skipped addresses.
- reset asserted mid-stream with 1 request outstanding → outputs immediately take reset values; imem_addr=RESET_PC after release; a spurious rvalid is ignored and flagged.
